// File: rtl/stream_credit_sink.sv
// Credit-based stream sink: requests bulk credit upstream, buffers matching beats in a FWFT FIFO.
// Optional STREAM_CREDIT_SINK_STATS_EN enables beat/packet counters on stat_Beats/stat_Packets.
module stream_credit_sink #(
  parameter  int DATA_WIDTH                  = 512,
  parameter  int STREAM_ID_NUM               = 16,
  parameter  int CHANNEL_ID_NUM              = 1024,
  parameter  int INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter  int FIFO_DEPTH                  = 16,
  parameter  int BULK_REQUEST_TRES           = 4,
  parameter  int CHUNK_ID_WIDTH              = 16,
  parameter  int STATE_WIDTH                 = 4,
  localparam int STREAM_ID_WIDTH             = $clog2(STREAM_ID_NUM),
  localparam int CHANNEL_ID_WIDTH            = $clog2(CHANNEL_ID_NUM)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [STREAM_ID_WIDTH-1:0]             cfg_StreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            cfg_ChannelID,
  input  logic [DATA_WIDTH-1:0]                  Front_Data,
  input  logic [1:0]                             Front_Type,
  input  logic                                   Front_Last,
  input  logic [STREAM_ID_WIDTH-1:0]             Front_StreamID,
  input  logic [CHUNK_ID_WIDTH-1:0]              Front_ChunkID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            Front_ChannelID,
  input  logic [STATE_WIDTH-1:0]                 Front_State,
  output logic [1:0]                             Front_InstructionType,
  output logic [STREAM_ID_WIDTH-1:0]             Front_InstructionStreamID,
  output logic [CHANNEL_ID_WIDTH-1:0]            Front_InstructionChannelID,
  output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Front_InstructionParameter,
  output logic [DATA_WIDTH-1:0]                  m_Data,
  output logic                                   m_Last,
  output logic                                   m_Valid,
  input  logic                                   m_Ready,
  output logic                                   overflow,
  output logic                                   busy,
  output logic [31:0]                            stat_Beats,
  output logic [31:0]                            stat_Packets
);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int IPW       = INSTRUCTION_PARAMETER_WIDTH;
  localparam int REQ_MIN   = (BULK_REQUEST_TRES < FIFO_DEPTH) ? BULK_REQUEST_TRES : FIFO_DEPTH;
  localparam int PARAM_MAX = (1 << IPW) - 1;

  typedef enum logic [1:0] {OFF, SEND_RESET, RUN, DRAIN} state_t;
  typedef enum logic [1:0] {INSTR_IDLE, INSTR_REQUEST, INSTR_REWIND, INSTR_RESET} instr_t;
  typedef struct packed {
    instr_t         kind;
    logic [IPW-1:0] param;
  } instr_s;

  state_t                      state, stateNext;
  instr_s                      issue;
  logic [STREAM_ID_WIDTH-1:0]  sidLat;
  logic [CHANNEL_ID_WIDTH-1:0] cidLat;
  logic [CNT_W-1:0]            outstanding, occ;
  logic [AW-1:0]               wrPtr, rdPtr;
  logic [DATA_WIDTH:0]         mem [FIFO_DEPTH];
  logic [31:0]                 freeCnt;
  logic                        accept, beatWr, beatDrop, pop;

  logic unusedFront;
  assign unusedFront = ^{Front_ChunkID, Front_State};

  assign accept   = (Front_Type == 2'd1) && (Front_StreamID == sidLat) &&
                    (Front_ChannelID == cidLat) && (state == RUN || state == DRAIN);
  assign beatWr   = accept && (outstanding != '0);
  assign beatDrop = accept && (outstanding == '0);
  assign m_Valid  = (occ != '0);
  assign pop      = m_Valid && m_Ready;
  assign {m_Last, m_Data} = mem[rdPtr];
  assign busy     = (state != OFF);
  // occ + outstanding never exceeds FIFO_DEPTH, so this cannot underflow
  assign freeCnt  = 32'(FIFO_DEPTH) - 32'(occ) - 32'(outstanding);

  always_comb begin
    stateNext   = state;
    issue.kind  = INSTR_IDLE;
    issue.param = '0;
    case (state)
      OFF:        if (enable) stateNext = SEND_RESET;
      SEND_RESET: begin
        issue.kind = INSTR_RESET;
        stateNext  = RUN;
      end
      RUN: begin
        if (!enable) stateNext = DRAIN;
        else if (freeCnt >= 32'(REQ_MIN)) begin
          issue.kind  = INSTR_REQUEST;
          issue.param = (freeCnt > 32'(PARAM_MAX)) ? IPW'(PARAM_MAX) : IPW'(freeCnt);
        end
      end
      DRAIN:      if (outstanding == '0) stateNext = OFF;
      default:    stateNext = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= OFF;
      sidLat                     <= '0;
      cidLat                     <= '0;
      outstanding                <= '0;
      occ                        <= '0;
      wrPtr                      <= '0;
      rdPtr                      <= '0;
      overflow                   <= 1'b0;
      Front_InstructionType      <= INSTR_IDLE;
      Front_InstructionParameter <= '0;
      Front_InstructionStreamID  <= '0;
      Front_InstructionChannelID <= '0;
    end else begin
      state <= stateNext;
      if (state == OFF && enable) begin
        sidLat <= cfg_StreamID;
        cidLat <= cfg_ChannelID;
      end
      Front_InstructionType      <= issue.kind;
      Front_InstructionParameter <= issue.param;
      Front_InstructionStreamID  <= (issue.kind != INSTR_IDLE) ? sidLat : '0;
      Front_InstructionChannelID <= (issue.kind != INSTR_IDLE) ? cidLat : '0;
      // granted credit and consumed credit land in the same cycle
      if (state == SEND_RESET) outstanding <= '0;
      else outstanding <= outstanding + CNT_W'(issue.param) - CNT_W'(beatWr);
      occ <= occ + CNT_W'(beatWr) - CNT_W'(pop);
      if (beatWr)   wrPtr    <= wrPtr + AW'(1);
      if (pop)      rdPtr    <= rdPtr + AW'(1);
      if (beatDrop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beatWr) mem[wrPtr] <= {Front_Last, Front_Data};
  end

`ifdef STREAM_CREDIT_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || state == SEND_RESET) begin
      stat_Beats   <= '0;
      stat_Packets <= '0;
    end else if (accept) begin
      stat_Beats <= stat_Beats + 32'd1;
      if (Front_Last) stat_Packets <= stat_Packets + 32'd1;
    end
  end
`else
  assign stat_Beats   = '0;
  assign stat_Packets = '0;
`endif
endmodule

// File: tb/tb_stream_credit_sink.sv
// Bench for stream_credit_sink: directed corner sequences, a filter table, and random traffic vs a queue model.
module tb_stream_credit_sink;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 10;

  logic          clk = 0;
  logic          rst, enable, Front_Last, m_Ready;
  logic [SW-1:0] cfg_StreamID, Front_StreamID, Front_InstructionStreamID;
  logic [CW-1:0] cfg_ChannelID, Front_ChannelID, Front_InstructionChannelID;
  logic [DW-1:0] Front_Data, m_Data;
  logic [1:0]    Front_Type, Front_InstructionType;
  logic [15:0]   Front_ChunkID, Front_InstructionParameter;
  logic [3:0]    Front_State;
  logic          m_Last, m_Valid, overflow, busy;
  logic [31:0]   stat_Beats, stat_Packets;

  stream_credit_sink #(.DATA_WIDTH(DW), .STREAM_ID_NUM(16), .CHANNEL_ID_NUM(1024),
    .INSTRUCTION_PARAMETER_WIDTH(16), .FIFO_DEPTH(16), .BULK_REQUEST_TRES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_StreamID(cfg_StreamID), .cfg_ChannelID(cfg_ChannelID),
    .Front_Data(Front_Data), .Front_Type(Front_Type), .Front_Last(Front_Last),
    .Front_StreamID(Front_StreamID), .Front_ChunkID(Front_ChunkID),
    .Front_ChannelID(Front_ChannelID), .Front_State(Front_State),
    .Front_InstructionType(Front_InstructionType),
    .Front_InstructionStreamID(Front_InstructionStreamID),
    .Front_InstructionChannelID(Front_InstructionChannelID),
    .Front_InstructionParameter(Front_InstructionParameter),
    .m_Data(m_Data), .m_Last(m_Last), .m_Valid(m_Valid), .m_Ready(m_Ready),
    .overflow(overflow), .busy(busy), .stat_Beats(stat_Beats), .stat_Packets(stat_Packets));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0=off 1=send-reset 2=run 3=drain; buffered beats as a queue, credit as an integer.
  int          mode, credit, latS, latC, expType, expParam, expS, expC;
  int unsigned mBeats, mPkts;
  bit          mOvf;
  bit [DW:0]   q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mode = 0; credit = 0; mOvf = 0; q.delete();
    expType = 0; expParam = 0; expS = 0; expC = 0; mBeats = 0; mPkts = 0;
  endtask

  task automatic modelEdge();
    bit acc, wr, drop, pop;
    int free, nType, nParam;
    if (rst) begin
      modelReset();
      return;
    end
    acc  = (mode == 2 || mode == 3) && Front_Type == 2'd1 &&
           int'(Front_StreamID) == latS && int'(Front_ChannelID) == latC;
    wr   = acc && credit > 0;
    drop = acc && credit == 0;
    pop  = q.size() > 0 && m_Ready;
    free = 16 - q.size() - credit;
    nType = 0; nParam = 0;
    if (mode == 1) nType = 3;
    else if (mode == 2 && enable && free >= 4) begin
      nType = 1;
      nParam = (free > 65535) ? 65535 : free;
    end
    expType = nType; expParam = nParam;
    expS = (nType != 0) ? latS : 0;
    expC = (nType != 0) ? latC : 0;
    if (pop) void'(q.pop_front());
    if (wr) q.push_back({Front_Last, Front_Data});
    if (drop) mOvf = 1;
    if (mode == 1) begin mBeats = 0; mPkts = 0; end
    else if (acc) begin mBeats++; if (Front_Last) mPkts++; end
    case (mode)
      0: if (enable) begin mode = 1; latS = int'(cfg_StreamID); latC = int'(cfg_ChannelID); end
      1: mode = 2;
      2: if (!enable) mode = 3;
      default: if (credit == 0) mode = 0;
    endcase
    credit = (nType == 3) ? 0 : credit + ((nType == 1) ? nParam : 0) - (wr ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    chk("instr_type", Front_InstructionType, expType);
    chk("instr_param", Front_InstructionParameter, expParam);
    chk("instr_sid", Front_InstructionStreamID, expS);
    chk("instr_cid", Front_InstructionChannelID, expC);
    chk("m_valid", m_Valid, q.size() > 0);
    if (q.size() > 0) chk("m_head", {m_Last, m_Data}, q[0]);
    chk("overflow", overflow, mOvf);
    chk("busy", busy, mode != 0);
`ifdef STREAM_CREDIT_SINK_STATS_EN
    chk("stat_beats", stat_Beats, mBeats);
    chk("stat_packets", stat_Packets, mPkts);
`else
    chk("stat_beats", stat_Beats, 0);
    chk("stat_packets", stat_Packets, 0);
`endif
  endtask

  task automatic beat(input logic [1:0] t, input int s, input int c, input logic [DW-1:0] d, input logic l);
    Front_Type = t; Front_StreamID = SW'(s); Front_ChannelID = CW'(c);
    Front_Data = d; Front_Last = l;
    Front_ChunkID = 16'($urandom); Front_State = 4'($urandom);
  endtask

  task automatic noBeat();
    beat(2'd0, 0, 0, '0, 1'b0);
  endtask

  typedef struct {
    logic [1:0]    t;
    int            s, c;
    logic [DW-1:0] d;
    logic          l;
    logic          expValid;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'd1, 3, 6, 32'hA0, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 3, 5, 32'hA1, 1'b1, 1'b1};
    tbl[2] = '{2'd2, 3, 5, 32'hA2, 1'b0, 1'b0};
    tbl[3] = '{2'd1, 3, 5, 32'hA3, 1'b0, 1'b1};
    tbl[4] = '{2'd3, 3, 5, 32'hA4, 1'b0, 1'b0};
    tbl[5] = '{2'd0, 3, 5, 32'hA5, 1'b0, 1'b0};
    tbl[6] = '{2'd1, 4, 5, 32'hA6, 1'b0, 1'b0};
    tbl[7] = '{2'd1, 3, 5, 32'hA7, 1'b1, 1'b1};
    tbl[8] = '{2'd1, 3, 5, 32'hA8, 1'b0, 1'b1};

    modelReset(); latS = 0; latC = 0;
    rst = 1; enable = 0; m_Ready = 0; cfg_StreamID = 0; cfg_ChannelID = 0; noBeat();
    step(); step();
    chk("rst_type", Front_InstructionType, 0);
    chk("rst_valid", m_Valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0; step();

    // bring-up: RESET then full-depth REQUEST
    cfg_StreamID = 4'd3; cfg_ChannelID = 10'd5; enable = 1;
    step(); chk("up_busy", busy, 1); chk("up_idle0", Front_InstructionType, 0);
    step(); chk("up_reset", {Front_InstructionType, Front_InstructionStreamID, Front_InstructionChannelID, Front_InstructionParameter},
                {2'd3, 4'd3, 10'd5, 16'd0});
    step(); chk("up_req", {Front_InstructionType, Front_InstructionParameter}, {2'd1, 16'd16});
    step(); chk("up_idle1", Front_InstructionType, 0);

    // fill to depth with consumer stalled, then pop until a bulk request is possible
    for (int i = 0; i < 16; i++) begin
      beat(2'd1, 3, 5, 32'(100 + i), (i % 4) == 3);
      step(); chk("fill_idle", Front_InstructionType, 0);
    end
    noBeat(); step();
    chk("fill_valid", m_Valid, 1); chk("fill_head", m_Data, 100);
    m_Ready = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("pop3_idle", Front_InstructionType, 0); end
    step(); m_Ready = 0; step();
    chk("pop4_req", {Front_InstructionType, Front_InstructionParameter}, {2'd1, 16'd4});
    m_Ready = 1; repeat (24) step();

    // address/type filtering
    for (int i = 0; i < 9; i++) begin
      m_Ready = 0; beat(tbl[i].t, tbl[i].s, tbl[i].c, tbl[i].d, tbl[i].l);
      step(); noBeat();
      chk("tbl_valid", m_Valid, tbl[i].expValid);
      if (tbl[i].expValid) chk("tbl_head", {m_Last, m_Data}, {tbl[i].l, tbl[i].d});
      m_Ready = 1; step();
    end
    m_Ready = 1; noBeat(); repeat (8) step();

    // exhaust credit, then one more beat must be dropped and overflow stick
    m_Ready = 0;
    for (int i = 0; i < 32 && credit > 0; i++) begin beat(2'd1, 3, 5, 32'($urandom), 1'b0); step(); end
    chk("pre_ovf", overflow, 0);
    beat(2'd1, 3, 5, 32'hDEAD, 1'b1); step(); noBeat();
    chk("drop_ovf", overflow, 1);
    m_Ready = 1; repeat (9) step(); m_Ready = 0;
    chk("ovf_sticky", overflow, 1);

    // reset with beats still buffered
    rst = 1; step();
    chk("mid_rst_valid", m_Valid, 0); chk("mid_rst_type", Front_InstructionType, 0);
    chk("mid_rst_ovf", overflow, 0); chk("mid_rst_beats", stat_Beats, 0);
    rst = 0;

    // disable with 5 credits outstanding: drain those beats, then go idle
    step(); step(); step();
    for (int i = 0; i < 11; i++) begin beat(2'd1, 3, 5, 32'(200 + i), 1'b0); step(); end
    enable = 0; noBeat(); step();
    chk("drain_busy", busy, 1); chk("drain_idle", Front_InstructionType, 0);
    for (int i = 0; i < 5; i++) begin
      beat(2'd1, 3, 5, 32'(300 + i), 1'b0); step();
      chk("drain_busy_b", busy, 1); chk("drain_noreq", Front_InstructionType, 0);
    end
    noBeat(); step(); chk("drain_off", busy, 0);
    m_Ready = 1; repeat (20) step();

    // random traffic against the model
    enable = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) enable = ~enable;
      rst = ($urandom_range(499) == 0);
      cfg_StreamID = $urandom_range(1) ? 4'd3 : 4'd2;
      cfg_ChannelID = 10'd5;
      beat(($urandom_range(9) < 7) ? 2'd1 : 2'($urandom),
           ($urandom_range(7) == 0) ? 2 : 3, ($urandom_range(9) == 0) ? 6 : 5,
           32'($urandom), 1'($urandom));
      m_Ready = ($urandom_range(2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
